// File: rtl/edu_tpu_wb_loader.sv
// Wishbone classic initiator that streams one edu_tpu job (weights, then inputs),
// waits for the array, then reads the result words back out on a valid/ready port.
//
// state | meaning
// IDLE  | waiting for start_i
// FETCH | src_ready_o high, waiting for a source word
// WRITE | write strobe held until ack or timeout
// GAP   | one idle bus cycle between transactions (write or read phase)
// WAIT  | READ_DELAY countdown while the array computes
// READ  | read strobe held until ack or timeout
// PUSH  | result word offered on res_* until accepted
// DONE  | one-cycle completion pulse
module edu_tpu_wb_loader #(
  parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
  parameter int          N_WEIGHT     = 4,
  parameter int          N_INPUT      = 5,
  parameter int          N_RESULT     = 5,
  parameter int          READ_DELAY   = 32,
  parameter int          TIMEOUT      = 255
) (
  input  logic        caravel_wb_clk_i,
  input  logic        caravel_wb_rst_n_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  input  logic        src_valid_i,
  output logic        src_ready_o,
  input  logic [31:0] src_data_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [31:0] res_data_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  localparam int CW = $clog2(N_WEIGHT + N_INPUT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int DW = $clog2(READ_DELAY + 2);

  localparam logic [CW-1:0] N_WR     = CW'(N_WEIGHT + N_INPUT);
  localparam logic [CW-1:0] N_RD     = CW'(N_RESULT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);
  localparam logic [DW-1:0] DLY_LOAD = DW'(READ_DELAY);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_READ  = 3'd5;
  localparam logic [2:0] S_PUSH  = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tmr;
  logic [DW-1:0] dly;
  logic          rd_phase;
  logic          err_pulse;
  logic          bus_cyc;

  // Bus controls decode straight from the state register so reset drops them at once.
  assign bus_cyc     = (state == S_WRITE) || (state == S_READ);
  assign wbm_cyc_o   = bus_cyc;
  assign wbm_stb_o   = bus_cyc;
  assign wbm_we_o    = (state == S_WRITE);
  assign wbm_sel_o   = bus_cyc ? 4'hF : 4'h0;
  assign wbm_adr_o   = bus_cyc ? BASE_ADDRESS : 32'h0;
  assign busy_o      = (state != S_IDLE);
  assign src_ready_o = (state == S_FETCH);
  assign res_valid_o = (state == S_PUSH);
  assign done_o      = (state == S_DONE);
  assign error_o     = err_pulse;

  always_ff @(posedge caravel_wb_clk_i or negedge caravel_wb_rst_n_i) begin
    if (!caravel_wb_rst_n_i) begin
      state      <= S_IDLE;
      cnt        <= '0;
      tmr        <= '0;
      dly        <= '0;
      rd_phase   <= 1'b0;
      err_pulse  <= 1'b0;
      wbm_dat_o  <= 32'h0;
      res_data_o <= 32'h0;
    end else begin
      err_pulse <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            cnt      <= '0;
            rd_phase <= 1'b0;
            state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (src_valid_i) begin
            wbm_dat_o <= src_data_i;
            tmr       <= TMR_LOAD;
            state     <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (wbm_ack_i) begin
            cnt   <= cnt + CNT_ONE;
            state <= S_GAP;
          end else if (tmr == '0) begin
            err_pulse <= 1'b1;
            state     <= S_IDLE;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        S_GAP: begin
          // The same idle cycle separates reads; rd_phase tells the two phases apart.
          if (rd_phase) begin
            tmr   <= TMR_LOAD;
            state <= S_READ;
          end else if (cnt < N_WR) begin
            state <= S_FETCH;
          end else begin
            cnt      <= '0;
            dly      <= DLY_LOAD;
            rd_phase <= 1'b1;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (dly == '0) begin
            tmr   <= TMR_LOAD;
            state <= S_READ;
          end else begin
            dly <= dly - DW'(1);
          end
        end
        S_READ: begin
          if (wbm_ack_i) begin
            res_data_o <= wbm_dat_i;
            state      <= S_PUSH;
          end else if (tmr == '0) begin
            err_pulse <= 1'b1;
            state     <= S_IDLE;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        S_PUSH: begin
          if (res_ready_i) begin
            cnt <= cnt + CNT_ONE;
            if ((cnt + CNT_ONE) < N_RD) state <= S_GAP;
            else                        state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
